irq_vector_ctrl: RTL and testbench
==================================

IRQ_VECTOR_CTRL -- requirements
Module: irq_vector_ctrl

Interface
REQ-001 Parameter N_CH, default 4, SHALL set the number of interrupt channels (2..32).
REQ-002 Parameter ADDR_W, default 32, SHALL set the vector address width.
REQ-003 Parameters VEC_BASE, default 0, and VEC_STRIDE, default 'h40, SHALL set reset vector of channel i to VEC_BASE + i*VEC_STRIDE.
REQ-004 Ports SHALL be, clock and reset first:
- in_clk  in  1  rising-edge clock
- in_rst_n  in  1  asynchronous active-low reset
- in_irq  in  N_CH  level sources, synchronous to in_clk
- in_mask  in  N_CH  1 = channel masked
- in_ie  in  1  global interrupt enable
- in_ack  in  1  CPU accepts the current request, one-cycle pulse
- in_eret  in  1  CPU returns from handler, one-cycle pulse
- in_vwe  in  1  vector table write strobe
- in_vidx  in  clog2(N_CH)  vector table write index
- in_vdata  in  ADDR_W  vector table write data
- out_req  out  1  interrupt request to CPU
- out_id  out  clog2(N_CH)  requesting channel
- out_vec  out  ADDR_W  handler address of out_id
- out_pending  out  N_CH  pending bits
- out_busy  out  1  any channel in service
REQ-005 The block SHALL use one clock, in_clk; reset in_rst_n SHALL be asynchronous and active-low.

Function
REQ-006 A 0->1 transition of in_irq[i] between consecutive clock edges SHALL set pending[i] on the following edge; levels do not re-trigger.
REQ-007 Priority SHALL be fixed: lower channel index wins.
REQ-008 Channel i is eligible when pending[i]=1, in_mask[i]=0, and i has strictly higher priority than the highest-priority in-service channel (any i if none in service).
REQ-009 Handshake FSM states SHALL be IDLE, REQ, ACKD.
REQ-010 IDLE: if in_ie=1 and any channel is eligible, latch the winner into out_id and its table entry into out_vec, and go to REQ.
REQ-011 REQ: out_req=1, with out_id/out_vec frozen; in_ack=1 clears pending[out_id], sets inservice[out_id], and goes to ACKD; in_ie=0 without ack returns to IDLE with pending untouched.
REQ-012 ACKD: out_req=0 for exactly one cycle, then IDLE.
REQ-013 Latency: edge sampled at cycle t -> pending at t+1 -> out_req at t+2.
REQ-014 in_ack outside REQ SHALL be ignored.
REQ-015 in_eret SHALL clear the highest-priority in-service bit; with none set it SHALL be ignored.
REQ-016 in_ack and in_eret in the same cycle: the eret clear is computed from current inservice, then the ack bit is set.
REQ-017 New edge on a channel in the cycle it is acked: pending stays 1.
REQ-018 Masking a pending channel SHALL keep it pending; unmasking makes it eligible again.
REQ-019 in_vwe SHALL write in_vdata to entry in_vidx on the clock edge; a write to the latched channel in REQ SHALL NOT change out_vec until the next arbitration.
REQ-020 out_busy = OR of inservice; out_pending = pending register.

Reset
REQ-021 Asserting in_rst_n low at any time, including mid-handshake, SHALL immediately force FSM=IDLE, out_req=0, out_id=0, out_vec=VEC_BASE, pending=0, inservice=0, out_busy=0, and the edge-detect history to 0.
REQ-022 Reset SHALL restore every vector entry to VEC_BASE + i*VEC_STRIDE.

Structure
REQ-023 Package irq_pkg SHALL hold the FSM state enum, the default parameter values, and a function computing default vectors.
REQ-024 Sub-module irq_prio_enc SHALL provide the N_CH-wide lowest-index-wins encoder (valid + index), instantiated twice: once for eligible arbitration and once for the highest in-service channel.

Verification (N_CH=4, defaults)
REQ-025 Pulse in_irq[2] at t -> out_req=1 at t+2 with out_id=2 and out_vec='h80; ack -> out_busy=1, pending=0.
REQ-026 Rising edges on ch3 and ch1 in the same cycle -> id=1 and vec='h40 first; after ack, ch3 is not requested until eret.
REQ-027 Ch2 in service; edge on ch0 -> nested request with id=0 and vec='h00; ack then two erets -> inservice clears ch0, then ch2.
REQ-028 Write vidx=3, vdata='h310; edge on ch3 -> out_vec='h310; reset -> entry 3 returns to 'hC0.
REQ-029 Ch1 masked and pending with in_ie=1 -> no req; unmask -> req id=1; drop in_ie while in REQ -> IDLE with pending[1] still 1.
REQ-030 Assert in_rst_n low while in REQ -> out_req=0 asynchronously and all state is cleared; ack and eret are ignored while idle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt vector controller.
// Holds the handshake state encoding and the reset vector-table formula.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACKD = 2'd2
    } irq_state_e;

    localparam int          N_CH_DEF       = 4;
    localparam int          ADDR_W_DEF     = 32;
    localparam logic [63:0] VEC_BASE_DEF   = 64'h0;
    localparam logic [63:0] VEC_STRIDE_DEF = 64'h40;

    function automatic logic [63:0] default_vec(input logic [63:0] base,
                                                input logic [63:0] stride,
                                                input int          idx);
        return base + stride * 64'(idx);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter  int N  = N_CH_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest requesting index is the last one written
    always_comb begin
        valid = 1'b0;
        idx   = {IW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx   = req[i] ? IW'(i) : idx;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Vectored interrupt controller: edge-latched pending bits, nested fixed-priority
// arbitration against the in-service set, and a REQ/ACK handshake to the CPU.
module irq_vector_ctrl
    import irq_pkg::*;
#(
    parameter  int          N_CH       = N_CH_DEF,
    parameter  int          ADDR_W     = ADDR_W_DEF,
    parameter  logic [63:0] VEC_BASE   = VEC_BASE_DEF,
    parameter  logic [63:0] VEC_STRIDE = VEC_STRIDE_DEF,
    localparam int          ID_W       = $clog2(N_CH)
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic [N_CH-1:0]   in_irq,
    input  logic [N_CH-1:0]   in_mask,
    input  logic              in_ie,
    input  logic              in_ack,
    input  logic              in_eret,
    input  logic              in_vwe,
    input  logic [ID_W-1:0]   in_vidx,
    input  logic [ADDR_W-1:0] in_vdata,
    output logic              out_req,
    output logic [ID_W-1:0]   out_id,
    output logic [ADDR_W-1:0] out_vec,
    output logic [N_CH-1:0]   out_pending,
    output logic              out_busy
);

    localparam logic [N_CH-1:0] ONE_HOT = {{(N_CH - 1){1'b0}}, 1'b1};

    irq_state_e        state_r, state_n_s;
    logic              req_r, req_n_s;
    logic [ID_W-1:0]   id_r, id_n_s;
    logic [ADDR_W-1:0] vec_r, vec_n_s;
    logic [N_CH-1:0]   irq_smp_r, irq_prev_r, rise_s;
    logic [N_CH-1:0]   pend_r, pend_n_s;
    logic [N_CH-1:0]   srv_r, srv_n_s;
    logic [N_CH-1:0]   elig_s, ack_set_s, eret_clr_s;
    logic              busy_r;
    logic              ack_ok_s;
    logic              win_valid_s, srv_valid_s;
    logic [ID_W-1:0]   win_idx_s, srv_idx_s;
    logic [ADDR_W-1:0] vtab_r [N_CH];

    irq_prio_enc #(.N(N_CH)) u_win_enc (
        .req   (elig_s),
        .valid (win_valid_s),
        .idx   (win_idx_s)
    );

    irq_prio_enc #(.N(N_CH)) u_srv_enc (
        .req   (srv_r),
        .valid (srv_valid_s),
        .idx   (srv_idx_s)
    );

    // Eligibility, pending and in-service next state
    always_comb begin
        rise_s   = irq_smp_r & ~irq_prev_r;
        ack_ok_s = (state_r == ST_REQ) && in_ack;
        for (int i = 0; i < N_CH; i++) begin
            elig_s[i] = pend_r[i] & ~in_mask[i] & (~srv_valid_s | (ID_W'(i) < srv_idx_s));
        end
        ack_set_s  = ack_ok_s ? (ONE_HOT << id_r) : {N_CH{1'b0}};
        eret_clr_s = (in_eret && srv_valid_s) ? (ONE_HOT << srv_idx_s) : {N_CH{1'b0}};
        // A fresh edge in the ack cycle re-arms the channel instead of being lost
        pend_n_s   = (pend_r & ~ack_set_s) | rise_s;
        srv_n_s    = (srv_r & ~eret_clr_s) | ack_set_s;
    end

    // Handshake FSM next state; id/vec only change when leaving IDLE
    always_comb begin
        state_n_s = state_r;
        req_n_s   = req_r;
        id_n_s    = id_r;
        vec_n_s   = vec_r;
        case (state_r)
            ST_IDLE: begin
                if (in_ie && win_valid_s) begin
                    state_n_s = ST_REQ;
                    req_n_s   = 1'b1;
                    id_n_s    = win_idx_s;
                    vec_n_s   = vtab_r[win_idx_s];
                end else begin
                    state_n_s = ST_IDLE;
                    req_n_s   = 1'b0;
                end
            end
            ST_REQ: begin
                if (in_ack) begin
                    state_n_s = ST_ACKD;
                    req_n_s   = 1'b0;
                end else if (!in_ie) begin
                    state_n_s = ST_IDLE;
                    req_n_s   = 1'b0;
                end else begin
                    state_n_s = ST_REQ;
                    req_n_s   = 1'b1;
                end
            end
            ST_ACKD: begin
                state_n_s = ST_IDLE;
                req_n_s   = 1'b0;
            end
            default: begin
                state_n_s = ST_IDLE;
                req_n_s   = 1'b0;
            end
        endcase
    end

    // Two-stage sampling of the sources gives the edge history
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            irq_smp_r  <= {N_CH{1'b0}};
            irq_prev_r <= {N_CH{1'b0}};
        end else begin
            irq_smp_r  <= in_irq;
            irq_prev_r <= irq_smp_r;
        end
    end

    // Handshake, pending and in-service registers
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            id_r    <= {ID_W{1'b0}};
            vec_r   <= ADDR_W'(VEC_BASE);
            pend_r  <= {N_CH{1'b0}};
            srv_r   <= {N_CH{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            req_r   <= req_n_s;
            id_r    <= id_n_s;
            vec_r   <= vec_n_s;
            pend_r  <= pend_n_s;
            srv_r   <= srv_n_s;
            busy_r  <= |srv_n_s;
        end
    end

    // Vector table with per-channel reset defaults
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                vtab_r[i] <= ADDR_W'(default_vec(VEC_BASE, VEC_STRIDE, i));
            end
        end else if (in_vwe) begin
            vtab_r[in_vidx] <= in_vdata;
        end
    end

    assign out_req     = req_r;
    assign out_id      = id_r;
    assign out_vec     = vec_r;
    assign out_pending = pend_r;
    assign out_busy    = busy_r;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed bench for irq_vector_ctrl (N_CH=4, default vectors 0/40/80/C0).
module tb_irq_vector_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  irq, mask;
    logic        ie, ack, eret, vwe;
    logic [1:0]  vidx;
    logic [31:0] vdata;
    logic        out_req;
    logic [1:0]  out_id;
    logic [31:0] out_vec;
    logic [3:0]  out_pending;
    logic        out_busy;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  irq;
        logic [3:0]  mask;
        logic        ie;
        logic        ack;
        logic        eret;
        logic        req;
        logic [1:0]  id;
        logic [31:0] vec;
        logic [3:0]  pend;
        logic        busy;
    } row_t;

    row_t tbl[$];

    irq_vector_ctrl dut (
        .in_clk      (clk),
        .in_rst_n    (rst_n),
        .in_irq      (irq),
        .in_mask     (mask),
        .in_ie       (ie),
        .in_ack      (ack),
        .in_eret     (eret),
        .in_vwe      (vwe),
        .in_vidx     (vidx),
        .in_vdata    (vdata),
        .out_req     (out_req),
        .out_id      (out_id),
        .out_vec     (out_vec),
        .out_pending (out_pending),
        .out_busy    (out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] a_irq, input logic [3:0] a_mask, input logic a_ie,
                       input logic a_ack, input logic a_eret, input logic e_req,
                       input logic [1:0] e_id, input logic [31:0] e_vec,
                       input logic [3:0] e_pend, input logic e_busy);
        row_t r;
        r.irq = a_irq; r.mask = a_mask; r.ie = a_ie; r.ack = a_ack; r.eret = a_eret;
        r.req = e_req; r.id = e_id; r.vec = e_vec; r.pend = e_pend; r.busy = e_busy;
        tbl.push_back(r);
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [1:0] e_id,
                           input logic [31:0] e_vec, input logic [3:0] e_pend, input logic e_busy);
        chk({tag, " req"},  32'(out_req),     32'(e_req));
        chk({tag, " id"},   32'(out_id),      32'(e_id));
        chk({tag, " vec"},  out_vec,          e_vec);
        chk({tag, " pend"}, 32'(out_pending), 32'(e_pend));
        chk({tag, " busy"}, 32'(out_busy),    32'(e_busy));
    endtask

    initial begin
        rst_n = 1'b0; irq = 4'h0; mask = 4'h0; ie = 1'b0; ack = 1'b0; eret = 1'b0;
        vwe = 1'b0; vidx = 2'd0; vdata = 32'h0;

        // irq   mask  ie    ack   eret | req  id    vec      pend  busy
        add(4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 1'b0); // ch2 sampled
        add(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h4, 1'b0); // pending at t+1
        add(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h80, 4'h4, 1'b0); // req at t+2
        add(4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h80, 4'h0, 1'b1); // ack
        add(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h80, 4'h0, 1'b1);
        add(4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h80, 4'h0, 1'b0); // eret
        add(4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h80, 4'h0, 1'b0); // ch3+ch1 together
        add(4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h80, 4'hA, 1'b0);
        add(4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h40, 4'hA, 1'b0);
        add(4'hA, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h40, 4'h8, 1'b1);
        add(4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h40, 4'h8, 1'b1);
        add(4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h40, 4'h8, 1'b1); // ch3 blocked
        add(4'hA, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h40, 4'h8, 1'b0);
        add(4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 32'hC0, 4'h8, 1'b0);
        add(4'hA, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 32'hC0, 4'h0, 1'b1);
        add(4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 32'hC0, 4'h0, 1'b0);
        add(4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'hC0, 4'h0, 1'b0); // nesting
        add(4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'hC0, 4'h4, 1'b0);
        add(4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h80, 4'h4, 1'b0);
        add(4'h4, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h80, 4'h0, 1'b1);
        add(4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h80, 4'h0, 1'b1);
        add(4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h80, 4'h1, 1'b1);
        add(4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h00, 4'h1, 1'b1); // nested req
        add(4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 1'b1);
        add(4'h5, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 4'h0, 1'b1); // clears ch0 only
        add(4'h7, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 1'b1);
        add(4'h7, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h2, 1'b1);
        add(4'h7, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h40, 4'h2, 1'b1); // ch2 still serviced
        add(4'h7, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 32'h40, 4'h0, 1'b1); // ack+eret
        add(4'h7, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h40, 4'h0, 1'b0);
        add(4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h40, 4'h0, 1'b0); // masking
        add(4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h40, 4'h0, 1'b0);
        add(4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h40, 4'h2, 1'b0);
        add(4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h40, 4'h2, 1'b0);
        add(4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h40, 4'h2, 1'b0); // unmask
        add(4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'h40, 4'h2, 1'b0); // ie drop
        add(4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'h40, 4'h2, 1'b0);
        add(4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h40, 4'h2, 1'b0);
        add(4'h2, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h40, 4'h0, 1'b1);
        add(4'h2, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h40, 4'h0, 1'b0);
        add(4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h40, 4'h0, 1'b0); // edge in ack cycle
        add(4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h40, 4'h1, 1'b0);
        add(4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h00, 4'h1, 1'b0);
        add(4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h00, 4'h1, 1'b0);
        add(4'h3, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h1, 1'b1);
        add(4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h1, 1'b1);
        add(4'h2, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 4'h1, 1'b0);
        add(4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h00, 4'h1, 1'b0);
        add(4'h2, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 1'b1);
        add(4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 4'h0, 1'b0);
        add(4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 1'b0); // ack while idle
        add(4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h00, 4'h0, 1'b0); // eret, none served

        repeat (2) tick();
        chk_all("reset", 1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            irq = tbl[k].irq; mask = tbl[k].mask; ie = tbl[k].ie;
            ack = tbl[k].ack; eret = tbl[k].eret;
            tick();
            chk_all($sformatf("row%0d", k), tbl[k].req, tbl[k].id, tbl[k].vec,
                    tbl[k].pend, tbl[k].busy);
        end
        ack = 1'b0; eret = 1'b0; irq = 4'h0; mask = 4'h0; ie = 1'b1;

        // Vector table write, then a write to the latched entry during REQ
        vwe = 1'b1; vidx = 2'd3; vdata = 32'h310;
        tick();
        vwe = 1'b0; irq = 4'h8;
        tick();
        irq = 4'h0;
        tick();
        chk("vw pend", 32'(out_pending), 32'h8);
        tick();
        chk_all("vw req", 1'b1, 2'd3, 32'h310, 4'h8, 1'b0);
        vwe = 1'b1; vdata = 32'h999;
        tick();
        vwe = 1'b0;
        chk("vw frozen vec", out_vec, 32'h310);
        ack = 1'b1;
        tick();
        ack = 1'b0; eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("vw busy cleared", 32'(out_busy), 32'h0);

        // Asynchronous reset while a request is outstanding
        mask = 4'h2; irq = 4'h6;
        tick();
        irq = 4'h0;
        tick();
        tick();
        chk_all("pre-rst", 1'b1, 2'd2, 32'h80, 4'h6, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async rst", 1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
        ack = 1'b1; eret = 1'b1;
        tick();
        ack = 1'b0; eret = 1'b0; mask = 4'h0;
        rst_n = 1'b1;
        tick();
        chk_all("post-rst", 1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0; eret = 1'b1;
        tick();
        eret = 1'b0;
        chk_all("idle ack/eret", 1'b0, 2'd0, 32'h0, 4'h0, 1'b0);

        // Entry 3 back to its reset default
        irq = 4'h8;
        tick();
        irq = 4'h0;
        tick();
        tick();
        chk_all("vec restored", 1'b1, 2'd3, 32'hC0, 4'h8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
